draw_engine: RTL and testbench
==============================

# draw_engine

Pixel-drawing responder for the game's animation controller. It accepts the level-type enable/select requests for screen, car-draw and car-erase operations. For each accepted request it sweeps the required pixels through synchronous image ROMs and drives the VGA adapter's plot interface. It reports completion on per-operation done levels.

## Interface
Parameters:
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- SPRITE_W, 8, car sprite width
- SPRITE_H, 8, car sprite height
- COLOR_W, 3, colour bits per pixel

Ports:
- clk  in  1  system clock, single domain
- reset  in  1  synchronous, active-high reset
- drawScreenEnable  in  1  request full-screen draw
- ScreenSelect  in  2  image: 0 MAP1, 1 MAP2, 2 START, 3 GG
- drawCarEnable  in  1  request car sprite draw
- eraseCarEnable  in  1  request car erase (restore background)
- car_x  in  8  sprite top-left x
- car_y  in  7  sprite top-left y
- rom_sel  out  2  screen ROM image select
- rom_addr  out  15  screen ROM address = y*SCREEN_W + x
- rom_data  in  COLOR_W  screen ROM data, 1-cycle read latency
- sprite_addr  out  6  sprite ROM address = sy*SPRITE_W + sx
- sprite_data  in  COLOR_W  sprite ROM data, 1-cycle read latency; 0 = transparent
- vga_x  out  8  plot x
- vga_y  out  7  plot y
- vga_colour  out  COLOR_W  plot colour
- vga_plot  out  1  plot strobe, one pixel per cycle
- drawScreenDone, drawCarDone, eraseCarDone  out  1 each  completion levels

## Operation
- States: IDLE, SCREEN, CAR, ERASE, DONE.
- IDLE accept priority when several enables are high: screen > erase > car.
- On accept, the block latches:
  - op select; ScreenSelect into scr_sel;
  - car_x and car_y into pos registers;
  - sweep counters reset to (0,0).
- On screen accept with ScreenSelect ∈ {0,1}, the block also latches bg_map := ScreenSelect[0]. bg_map is 0 at reset.
- Sweep is raster order, x fastest; one address per cycle.
- SCREEN sweep:
  - rom_sel = scr_sel;
  - covers SCREEN_W×SCREEN_H pixels.
- CAR sweep:
  - sprite_addr walks 0..63;
  - screen position is pos + (sx,sy);
  - colour comes from sprite_data;
  - plot is suppressed when the colour is 0.
- ERASE sweep:
  - same positions as CAR;
  - rom_sel = bg_map;
  - rom_addr is the screen address of each position;
  - colour comes from rom_data;
  - every in-screen pixel is plotted.
- Clipping: a sprite pixel with x ≥ SCREEN_W or y ≥ SCREEN_H has plot suppressed but still consumes its cycle. Position arithmetic is 9-bit x / 8-bit y, so there is no wrap-around.
- Pipeline: x, y, valid and suppress are delayed one stage to align with ROM data. vga_x/vga_y/vga_plot/vga_colour are the delayed values.
- When the last address has been issued and its plot has drained, the block enters DONE. The matching done output is high in DONE.
- DONE exit:
  - the op's enable low → IDLE; done low next cycle;
  - SCREEN op, drawScreenEnable still high, ScreenSelect ≠ scr_sel → restart SCREEN with the new select; done low next cycle;
  - otherwise hold DONE.
- Abort: if the active op's enable drops mid-sweep, the block goes to IDLE next cycle. vga_plot is forced 0 from that cycle, and no done is asserted.

## Timing
- Reset values:
  - state IDLE; all done outputs 0;
  - vga_plot 0; vga_x 0, vga_y 0, vga_colour 0;
  - rom_addr 0, sprite_addr 0, rom_sel 0;
  - bg_map 0; scr_sel 2.
- Let S be the first cycle in SCREEN, CAR or ERASE. Accept takes one cycle, so S is the cycle after the enable is first seen in IDLE.
- Address for pixel i is issued in cycle S+i; its plot appears at S+i+1.
- SCREEN: 19200 address cycles; last plot at S+19200; done high from S+19201.
- CAR/ERASE: 64 address cycles; last plot at S+64; done high from S+65.
- Done to DONE-exit reaction is 1 cycle. A restart's new sweep starts at the cycle after done drops (new S).
- Reset asserted mid-sweep: next edge is the reset state, and no further plots occur.

## Test plan
- Reset then drawScreenEnable=1, ScreenSelect=2 → first plot (0,0) at S+1 with rom_sel=2; exactly 19200 plots; last plot (159,119); drawScreenDone=1 from S+19201 and held.
- While in DONE, ScreenSelect changes 2→1 with enable held → drawScreenDone=0 next cycle; new sweep with rom_sel=1; done again after 19200 plots; bg_map=1.
- drawCarEnable at car_x=156, car_y=118, with sprite ROM all 5 except address 0 = 0 → 7 plots (4×2 in-screen minus one transparent); drawCarDone at S+65.
- eraseCarEnable at (10,20) after a MAP2 draw → 64 plots at x 10..17, y 20..27, rom_sel=1, rom_addr=y*160+x; eraseCarDone at S+65.
- drawScreenEnable and drawCarEnable raised in the same cycle from IDLE → SCREEN runs first. drawScreenEnable dropped at S+100 → vga_plot 0 from the next cycle, no done, return to IDLE; CAR is accepted on the following cycle.
- reset pulsed at S+30 of a CAR sweep → all outputs at reset values next cycle; no plot afterwards; state IDLE.

Source files
------------

// File: rtl/draw_engine.sv
// Pixel-drawing responder: sweeps screen or sprite ROMs in raster order and drives the
// VGA plot interface, with a one-stage pipeline aligning position with ROM read data.
module draw_engine #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned SPRITE_W = 8,
  parameter int unsigned SPRITE_H = 8,
  parameter int unsigned COLOR_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               drawScreenEnable,
  input  logic [1:0]         ScreenSelect,
  input  logic               drawCarEnable,
  input  logic               eraseCarEnable,
  input  logic [7:0]         car_x,
  input  logic [6:0]         car_y,
  output logic [1:0]         rom_sel,
  output logic [14:0]        rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [5:0]         sprite_addr,
  input  logic [COLOR_W-1:0] sprite_data,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               vga_plot,
  output logic               drawScreenDone,
  output logic               drawCarDone,
  output logic               eraseCarDone
);

  typedef enum logic [2:0] {StIdle, StScreen, StCar, StErase, StDone} state_e;
  typedef enum logic [1:0] {OpScreen, OpCar, OpErase} op_e;

  localparam logic [7:0] ScrXMax = 8'(SCREEN_W - 1);
  localparam logic [6:0] ScrYMax = 7'(SCREEN_H - 1);
  localparam logic [7:0] SprXMax = 8'(SPRITE_W - 1);
  localparam logic [6:0] SprYMax = 7'(SPRITE_H - 1);

  state_e       state_q;
  op_e          op_q;
  logic [1:0]   scr_sel_q;
  logic         bg_map_q;
  logic [7:0]   pos_x_q;
  logic [6:0]   pos_y_q;
  logic [7:0]   sx_q;
  logic [6:0]   sy_q;
  logic         draining_q;

  // Pipeline stage aligned with the 1-cycle ROM read latency
  logic         pv_q;
  logic         ps_q;
  logic         pc_q;
  logic [7:0]   vx_q;
  logic [6:0]   vy_q;

  logic         sweep;
  logic         issuing;
  logic [8:0]   pix_x;
  logic [7:0]   pix_y;
  logic         last_x;
  logic         last_y;
  logic         op_en;
  logic         off_screen;

  always_comb begin
    sweep   = (state_q == StScreen) || (state_q == StCar) || (state_q == StErase);
    issuing = sweep && !draining_q;
    if (op_q == OpScreen) begin
      pix_x  = {1'b0, sx_q};
      pix_y  = {1'b0, sy_q};
      last_x = (sx_q == ScrXMax);
      last_y = (sy_q == ScrYMax);
    end else begin
      pix_x  = {1'b0, pos_x_q} + {1'b0, sx_q};
      pix_y  = {1'b0, pos_y_q} + {1'b0, sy_q};
      last_x = (sx_q == SprXMax);
      last_y = (sy_q == SprYMax);
    end
    off_screen = (32'(pix_x) >= SCREEN_W) || (32'(pix_y) >= SCREEN_H);
    case (op_q)
      OpScreen: op_en = drawScreenEnable;
      OpCar:    op_en = drawCarEnable;
      OpErase:  op_en = eraseCarEnable;
      default:  op_en = 1'b0;
    endcase
  end

  always_comb begin
    rom_sel     = 2'd0;
    rom_addr    = 15'd0;
    sprite_addr = 6'd0;
    if (state_q == StScreen || state_q == StErase) begin
      rom_sel  = (state_q == StScreen) ? scr_sel_q : {1'b0, bg_map_q};
      rom_addr = 15'(32'(pix_y) * SCREEN_W + 32'(pix_x));
    end
    if (state_q == StCar) begin
      sprite_addr = 6'(32'(sy_q) * SPRITE_W + 32'(sx_q));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= OpScreen;
      scr_sel_q  <= 2'd2;
      bg_map_q   <= 1'b0;
      pos_x_q    <= 8'd0;
      pos_y_q    <= 7'd0;
      sx_q       <= 8'd0;
      sy_q       <= 7'd0;
      draining_q <= 1'b0;
      pv_q       <= 1'b0;
      ps_q       <= 1'b0;
      pc_q       <= 1'b0;
      vx_q       <= 8'd0;
      vy_q       <= 7'd0;
    end else begin
      pv_q <= issuing;
      ps_q <= off_screen;
      pc_q <= (op_q == OpCar);
      vx_q <= pix_x[7:0];
      vy_q <= pix_y[6:0];
      case (state_q)
        StIdle: begin
          if (drawScreenEnable || eraseCarEnable || drawCarEnable) begin
            scr_sel_q  <= ScreenSelect;
            pos_x_q    <= car_x;
            pos_y_q    <= car_y;
            sx_q       <= 8'd0;
            sy_q       <= 7'd0;
            draining_q <= 1'b0;
          end
          if (drawScreenEnable) begin
            op_q    <= OpScreen;
            state_q <= StScreen;
            if (!ScreenSelect[1]) bg_map_q <= ScreenSelect[0];
          end else if (eraseCarEnable) begin
            op_q    <= OpErase;
            state_q <= StErase;
          end else if (drawCarEnable) begin
            op_q    <= OpCar;
            state_q <= StCar;
          end
        end
        StScreen, StCar, StErase: begin
          if (!op_en) begin
            // Abort: kill the in-flight plot as well
            state_q <= StIdle;
            pv_q    <= 1'b0;
          end else if (draining_q) begin
            state_q <= StDone;
          end else if (last_x) begin
            sx_q <= 8'd0;
            if (last_y) draining_q <= 1'b1;
            else        sy_q <= sy_q + 7'd1;
          end else begin
            sx_q <= sx_q + 8'd1;
          end
        end
        StDone: begin
          if (!op_en) begin
            state_q <= StIdle;
          end else if (op_q == OpScreen && ScreenSelect != scr_sel_q) begin
            state_q    <= StScreen;
            scr_sel_q  <= ScreenSelect;
            sx_q       <= 8'd0;
            sy_q       <= 7'd0;
            draining_q <= 1'b0;
            if (!ScreenSelect[1]) bg_map_q <= ScreenSelect[0];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    vga_x      = vx_q;
    vga_y      = vy_q;
    vga_colour = pv_q ? (pc_q ? sprite_data : rom_data) : '0;
    vga_plot   = pv_q && !ps_q && !(pc_q && sprite_data == '0);
  end

  assign drawScreenDone = (state_q == StDone) && (op_q == OpScreen);
  assign drawCarDone    = (state_q == StDone) && (op_q == OpCar);
  assign eraseCarDone   = (state_q == StDone) && (op_q == OpErase);

endmodule

// File: tb/tb_draw_engine.sv
// Self-checking bench for draw_engine: ROM models, a plot-list reference model,
// table-driven sprite vectors, hand sequences for restart/abort/reset, random ops.
module tb_draw_engine;
  localparam int W = 160;
  localparam int H = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       drawScreenEnable = 1'b0;
  logic [1:0] ScreenSelect = 2'd0;
  logic       drawCarEnable = 1'b0;
  logic       eraseCarEnable = 1'b0;
  logic [7:0] car_x = 8'd0;
  logic [6:0] car_y = 7'd0;
  logic [1:0] rom_sel;
  logic [14:0] rom_addr;
  logic [2:0] rom_data;
  logic [5:0] sprite_addr;
  logic [2:0] sprite_data;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       drawScreenDone, drawCarDone, eraseCarDone;

  draw_engine dut (
    .clk(clk), .reset(reset),
    .drawScreenEnable(drawScreenEnable), .ScreenSelect(ScreenSelect),
    .drawCarEnable(drawCarEnable), .eraseCarEnable(eraseCarEnable),
    .car_x(car_x), .car_y(car_y),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .sprite_addr(sprite_addr), .sprite_data(sprite_data),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .drawScreenDone(drawScreenDone), .drawCarDone(drawCarDone), .eraseCarDone(eraseCarDone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] img(input int sel, input int a);
    int h;
    h = a ^ (a >> 3) ^ (a >> 7);
    return 3'((h + 3 * sel + a / 97) & 7);
  endfunction

  logic [2:0] sprite_mem [64];

  always @(posedge clk) begin
    rom_data    <= img(int'(rom_sel), int'(rom_addr));
    sprite_data <= sprite_mem[sprite_addr];
  end

  typedef struct {
    int x;
    int y;
    int c;
    int cy;
  } plot_t;

  plot_t act_q[$];
  plot_t exp_q[$];
  int    scr_done_cnt = 0;

  always @(negedge clk) begin
    plot_t p;
    if (vga_plot) begin
      p.x  = int'(vga_x);
      p.y  = int'(vga_y);
      p.c  = int'(vga_colour);
      p.cy = cyc;
      act_q.push_back(p);
    end
    if (drawScreenDone) scr_done_cnt = scr_done_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int bg_model = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // op 0 screen (sel = image), 1 car, 2 erase (sel = background); pixel i plots at s+1+i
  task automatic model_sweep(input int op, input int cx, input int cy, input int sel,
                             input int s);
    plot_t p;
    if (op == 0) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          p.x = x; p.y = y; p.c = int'(img(sel, y * W + x)); p.cy = s + 1 + y * W + x;
          exp_q.push_back(p);
        end
    end else begin
      for (int sy = 0; sy < 8; sy++)
        for (int sx = 0; sx < 8; sx++) begin
          p.x = cx + sx; p.y = cy + sy; p.cy = s + 1 + sy * 8 + sx;
          if (p.x < W && p.y < H) begin
            if (op == 2) begin
              p.c = int'(img(sel, p.y * W + p.x));
              exp_q.push_back(p);
            end else if (sprite_mem[sy * 8 + sx] != 3'd0) begin
              p.c = int'(sprite_mem[sy * 8 + sx]);
              exp_q.push_back(p);
            end
          end
        end
    end
  endtask

  task automatic compare_plots(input string name, input int mark);
    int n;
    int bad;
    n = act_q.size() - mark;
    check({name, " plot count"}, n, exp_q.size());
    bad = -1;
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      if (act_q[mark + i] != exp_q[i]) begin
        bad = i;
        break;
      end
    end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s plot %0d: got (%0d,%0d) c=%0d @%0d, expected (%0d,%0d) c=%0d @%0d",
               name, bad, act_q[mark + bad].x, act_q[mark + bad].y, act_q[mark + bad].c,
               act_q[mark + bad].cy, exp_q[bad].x, exp_q[bad].y, exp_q[bad].c,
               exp_q[bad].cy);
    end
  endtask

  task automatic set_en(input int op, input logic v);
    case (op)
      0: drawScreenEnable = v;
      1: drawCarEnable = v;
      default: eraseCarEnable = v;
    endcase
  endtask

  function automatic logic get_done(input int op);
    case (op)
      0: return drawScreenDone;
      1: return drawCarDone;
      default: return eraseCarDone;
    endcase
  endfunction

  task automatic wait_done(input int op, input int budget, output int dc);
    dc = -1;
    for (int j = 0; j < budget; j++) begin
      @(negedge clk);
      if (get_done(op)) begin
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic run_small(input int op, input int cx, input int cy, input int exp_plots,
                           input string name);
    int s, dc, mark;
    @(posedge clk); #1;
    car_x = 8'(cx);
    car_y = 7'(cy);
    set_en(op, 1'b1);
    s = cyc + 1;
    mark = act_q.size();
    exp_q.delete();
    model_sweep(op, cx, cy, bg_model, s);
    @(negedge clk); @(negedge clk); @(negedge clk);
    if (op == 2) begin
      check({name, " rom_sel"}, int'(rom_sel), bg_model);
      check({name, " rom_addr"}, int'(rom_addr), (cy * W + cx + 1) & 32767);
    end else begin
      check({name, " sprite_addr"}, int'(sprite_addr), 1);
    end
    wait_done(op, 200, dc);
    check({name, " done cycle"}, dc, s + 65);
    @(posedge clk); #1;
    set_en(op, 1'b0);
    @(negedge clk); @(negedge clk);
    check({name, " done released"}, int'(get_done(op)), 0);
    compare_plots(name, mark);
    if (exp_plots >= 0) check({name, " table plot count"}, act_q.size() - mark, exp_plots);
  endtask

  typedef struct {
    int op;
    int cx;
    int cy;
    int exp_plots;
  } vec_t;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    int s, dc, mark, c, scr0;

    vecs[0] = '{1, 156, 118, 7};
    vecs[1] = '{2, 10, 20, 64};
    vecs[2] = '{1, 0, 0, 63};
    vecs[3] = '{2, 155, 115, 25};
    vecs[4] = '{1, 159, 119, 0};
    vecs[5] = '{2, 200, 100, 0};
    vecs[6] = '{1, 152, 112, 63};
    vecs[7] = '{2, 159, 0, 8};

    for (int i = 0; i < 64; i++) sprite_mem[i] = 3'd5;
    sprite_mem[0] = 3'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset vga_plot", int'(vga_plot), 0);
    check("reset vga_x", int'(vga_x), 0);
    check("reset vga_y", int'(vga_y), 0);
    check("reset vga_colour", int'(vga_colour), 0);
    check("reset rom_addr", int'(rom_addr), 0);
    check("reset rom_sel", int'(rom_sel), 0);
    check("reset sprite_addr", int'(sprite_addr), 0);
    check("reset dones", int'({drawScreenDone, drawCarDone, eraseCarDone}), 0);
    reset = 1'b0;

    // Full-screen START draw, then restart with MAP2 while done is held
    @(posedge clk); #1;
    ScreenSelect = 2'd2;
    drawScreenEnable = 1'b1;
    s = cyc + 1;
    mark = act_q.size();
    exp_q.delete();
    model_sweep(0, 0, 0, 2, s);
    @(negedge clk); @(negedge clk);
    check("screen2 rom_sel", int'(rom_sel), 2);
    wait_done(0, 19400, dc);
    check("screen2 done cycle", dc, s + 19201);
    repeat (3) @(negedge clk);
    check("screen2 done held", int'(drawScreenDone), 1);
    compare_plots("screen2", mark);

    @(posedge clk); #1;
    ScreenSelect = 2'd1;
    c = cyc;
    s = c + 1;
    mark = act_q.size();
    exp_q.delete();
    model_sweep(0, 0, 0, 1, s);
    @(negedge clk); @(negedge clk);
    check("restart done drops", int'(drawScreenDone), 0);
    check("restart rom_sel", int'(rom_sel), 1);
    wait_done(0, 19400, dc);
    check("screen1 done cycle", dc, s + 19201);
    compare_plots("screen1", mark);
    bg_model = 1;
    @(posedge clk); #1;
    drawScreenEnable = 1'b0;
    @(negedge clk); @(negedge clk);
    check("screen1 done released", int'(drawScreenDone), 0);

    for (int i = 0; i < 8; i++)
      run_small(vecs[i].op, vecs[i].cx, vecs[i].cy, vecs[i].exp_plots,
                $sformatf("vec%0d", i));

    // Screen beats car; screen aborted at S+100, car follows
    for (int i = 0; i < 64; i++) sprite_mem[i] = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    ScreenSelect = 2'd0;
    car_x = 8'd30;
    car_y = 7'd40;
    drawScreenEnable = 1'b1;
    drawCarEnable = 1'b1;
    s = cyc + 1;
    bg_model = 0;
    mark = act_q.size();
    scr0 = scr_done_cnt;
    exp_q.delete();
    begin
      plot_t p;
      for (int i = 0; i < 100; i++) begin
        p.x = i; p.y = 0; p.c = int'(img(0, i)); p.cy = s + 1 + i;
        exp_q.push_back(p);
      end
    end
    model_sweep(1, 30, 40, 0, s + 102);
    while (cyc < s + 100) begin
      @(posedge clk); #1;
    end
    drawScreenEnable = 1'b0;
    wait_done(1, 300, dc);
    check("abort then car done cycle", dc, s + 102 + 65);
    check("abort no screen done", scr_done_cnt - scr0, 0);
    @(posedge clk); #1;
    drawCarEnable = 1'b0;
    @(negedge clk); @(negedge clk);
    compare_plots("abort+car", mark);

    for (int k = 0; k < 8; k++) begin
      int op, cx, cy;
      op = int'($urandom_range(1, 2));
      cx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(145, 165));
      cy = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 127))
                                       : int'($urandom_range(108, 125));
      for (int i = 0; i < 64; i++) sprite_mem[i] = 3'($urandom_range(0, 7));
      run_small(op, cx, cy, -1, $sformatf("rand%0d", k));
    end

    // Reset during a car sweep at S+30
    for (int i = 0; i < 64; i++) sprite_mem[i] = 3'(1 + i % 7);
    @(posedge clk); #1;
    car_x = 8'd40;
    car_y = 7'd40;
    drawCarEnable = 1'b1;
    s = cyc + 1;
    mark = act_q.size();
    exp_q.delete();
    model_sweep(1, 40, 40, 0, s);
    while (exp_q.size() > 0 && exp_q[$].cy > s + 30) void'(exp_q.pop_back());
    while (cyc < s + 30) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    drawCarEnable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset vga_plot", int'(vga_plot), 0);
    check("midreset vga_xy", int'({vga_x, vga_y}), 0);
    check("midreset vga_colour", int'(vga_colour), 0);
    check("midreset sprite_addr", int'(sprite_addr), 0);
    check("midreset rom", int'({rom_sel, rom_addr}), 0);
    check("midreset dones", int'({drawScreenDone, drawCarDone, eraseCarDone}), 0);
    repeat (80) @(negedge clk);
    compare_plots("midreset", mark);
    check("midreset dones later", int'({drawScreenDone, drawCarDone, eraseCarDone}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
